alu: RTL and testbench
======================

# alu

32-bit integer arithmetic/logic unit for the core's execute stage. Computes one of twelve operations on two 32-bit operands, selected by a 4-bit control code. Registers the result and a zero flag. Result feeds writeback; the zero flag feeds branch resolution.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  reset, asynchronous, active-high.
- a  input  32  operand A; the shifted value for shifts.
- b  input  32  operand B; b[4:0] is the shift amount for shifts.
- Alu_ctrl  input  4  operation select.
- Result  output  32  registered operation result.
- Zero  output  1  registered flag, 1 when the registered Result equals 32'h0.

## Operation
- Alu_ctrl encoding:
  - 0000 ADD: a + b, modulo 2^32, carry discarded.
  - 0001 SUB: a - b, modulo 2^32, borrow discarded.
  - 0010 AND: a & b.
  - 0011 OR: a | b.
  - 0100 XOR: a ^ b.
  - 0101 SLL: a << b[4:0], zero fill.
  - 0110 SRL: a >> b[4:0], logical, zero fill.
  - 0111 SRA: a >>> b[4:0], arithmetic, replicates a[31].
  - 1000 SLTU: 32'd1 if a < b unsigned, else 32'd0.
  - 1001 SLT: 32'd1 if a < b two's-complement signed, else 32'd0.
  - 1010 NOR: ~(a | b).
  - 1011 PASSB: b.
  - 1100-1111 reserved: result 32'h0, so Zero=1.
- b[31:5] is ignored for all shift operations; a shift of 0 passes a through unchanged.
- No overflow or carry is reported. Wrap-around is silent: 32'hFFFFFFFF + 1 gives 0 with Zero=1.
- Zero is computed from the combinational result of the same operation and registered together with Result. Zero always matches the Result value presented alongside it.
- SLT and SLTU with a == b give 0.

## Timing
- Operation is combinational from a, b, Alu_ctrl to the result. Result and Zero are captured on each rising clk edge.
- Latency is 1 cycle: inputs stable before edge N appear on Result/Zero after edge N.
- There is no enable or handshake. A new operation is accepted every cycle, with throughput of one per clock.
- Inputs changing between edges have no effect on outputs until the next edge.
- While rst=1, without waiting for a clock edge: Result = 32'h0 and Zero = 1.
- Reset asserted mid-stream discards the in-flight operation. After rst deasserts, the first rising edge captures the current inputs.
- Reserved codes and every other input pattern produce defined outputs; no X propagates from valid inputs.

## Test plan
- Reset: assert rst asynchronously with nonzero Result pending -> Result=0 and Zero=1 immediately; both hold until the first edge after release.
- Add/sub: a=10, b=20, ctrl=0000 -> Result=30, Zero=0 one edge later. a=20, b=15, ctrl=0001 -> 5, Zero=0. a=100, b=100, ctrl=0001 -> 0, Zero=1. a=32'hFFFFFFFF, b=1, ADD -> 0, Zero=1.
- Logic ops: a=4'b1010, b=4'b1100 -> AND 8, OR 14, XOR 6, NOR 32'hFFFFFFF1.
- Shifts: a=1, b=2, SLL -> 4. a=32'h80000000, b=4: SRL -> 32'h08000000, SRA -> 32'hF8000000. a=1, b=32'h00000021, SLL -> 2, confirming only b[4:0] is used.
- Compares: a=-10 (32'hFFFFFFF6), b=5: SLT -> 1, Zero=0; SLTU -> 0, Zero=1. a == b -> SLT=0 and SLTU=0.
- Pipelining: change ctrl and operands every cycle through all 16 codes -> each Result matches the previous cycle's inputs; reserved codes 1100-1111 give 0 with Zero=1; PASSB with b=32'hDEADBEEF gives 32'hDEADBEEF.

Source files
------------

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit execute-stage ALU with registered result and zero flag
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  Alu_ctrl,
  output logic [31:0] Result,
  output logic        Zero
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_SLT   = 4'b1001,
    OP_NOR   = 4'b1010,
    OP_PASSB = 4'b1011
  } alu_op_e;

  logic [31:0] result_c;
  logic [4:0]  shamt;
  logic [31:0] sra_c;

  assign shamt = b[4:0];
  assign sra_c = 32'($signed(a) >>> shamt);

  // Reserved codes fall through to the zero default.
  always_comb begin
    result_c = 32'h0;
    case (Alu_ctrl)
      OP_ADD:   result_c = a + b;
      OP_SUB:   result_c = a - b;
      OP_AND:   result_c = a & b;
      OP_OR:    result_c = a | b;
      OP_XOR:   result_c = a ^ b;
      OP_SLL:   result_c = a << shamt;
      OP_SRL:   result_c = a >> shamt;
      OP_SRA:   result_c = sra_c;
      OP_SLTU:  result_c = {31'b0, (a < b)};
      OP_SLT:   result_c = {31'b0, ($signed(a) < $signed(b))};
      OP_NOR:   result_c = ~(a | b);
      OP_PASSB: result_c = b;
      default:  result_c = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result <= 32'h0;
      Zero   <= 1'b1;
    end else begin
      Result <= result_c;
      Zero   <= (result_c == 32'h0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu with directed steps and a code sweep
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  Alu_ctrl;
  logic [31:0] Result;
  logic        Zero;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_res_q[$];
  logic        exp_zero_q[$];
  string       exp_tag_q[$];

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .Alu_ctrl (Alu_ctrl),
    .Result   (Result),
    .Zero     (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] op);
    logic signed [31:0] sx;
    int sh;
    sx = x;
    sh = int'(y[4:0]);
    case (op)
      4'd0:  return x + y;
      4'd1:  return x + (~y + 32'd1);
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return x << sh;
      4'd6:  return x >> sh;
      4'd7:  return sx >>> sh;
      4'd8:  return (x < y) ? 32'd1 : 32'd0;
      4'd9:  return (sx < $signed(y)) ? 32'd1 : 32'd0;
      4'd10: return ~(x | y);
      4'd11: return y;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] er, input logic ez);
    n_cmp++;
    assert ({Result, Zero} === {er, ez}) else begin
      n_err++;
      $error("FAIL %s: got Result=%h Zero=%b, expected Result=%h Zero=%b",
             tag, Result, Zero, er, ez);
    end
  endtask

  // Drive at the falling edge, queue the expectation, compare just after the capture edge.
  task automatic step(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic [3:0] op, input logic [31:0] er, input logic ez);
    logic [31:0] r;
    logic        z;
    string       t;
    @(negedge clk);
    a = x;
    b = y;
    Alu_ctrl = op;
    exp_res_q.push_back(er);
    exp_zero_q.push_back(ez);
    exp_tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_res_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: scoreboard empty, got Result=%h expected an entry", tag, Result);
    end else begin
      r = exp_res_q.pop_front();
      z = exp_zero_q.pop_front();
      t = exp_tag_q.pop_front();
      check(t, r, z);
    end
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
    rst = 1'b1;
    a = 32'h0;
    b = 32'h0;
    Alu_ctrl = 4'h0;
    #1;
    check("reset_initial", 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    step("add_10_20",   32'd10,        32'd20, 4'b0000, 32'd30, 1'b0);
    step("sub_20_15",   32'd20,        32'd15, 4'b0001, 32'd5,  1'b0);
    step("sub_eq",      32'd100,       32'd100, 4'b0001, 32'd0, 1'b1);
    step("add_wrap",    32'hFFFFFFFF,  32'd1,  4'b0000, 32'd0,  1'b1);
    step("and",         32'b1010,      32'b1100, 4'b0010, 32'd8,  1'b0);
    step("or",          32'b1010,      32'b1100, 4'b0011, 32'd14, 1'b0);
    step("xor",         32'b1010,      32'b1100, 4'b0100, 32'd6,  1'b0);
    step("nor",         32'b1010,      32'b1100, 4'b1010, 32'hFFFFFFF1, 1'b0);
    step("sll",         32'd1,         32'd2,  4'b0101, 32'd4,  1'b0);
    step("srl",         32'h80000000,  32'd4,  4'b0110, 32'h08000000, 1'b0);
    step("sra",         32'h80000000,  32'd4,  4'b0111, 32'hF8000000, 1'b0);
    step("sll_b_hi",    32'd1,         32'h21, 4'b0101, 32'd2,  1'b0);
    step("sra_zero_sh", 32'h80000001,  32'h20, 4'b0111, 32'h80000001, 1'b0);
    step("slt_neg",     32'hFFFFFFF6,  32'd5,  4'b1001, 32'd1,  1'b0);
    step("sltu_neg",    32'hFFFFFFF6,  32'd5,  4'b1000, 32'd0,  1'b1);
    step("slt_eq",      32'h1234,      32'h1234, 4'b1001, 32'd0, 1'b1);
    step("sltu_eq",     32'h1234,      32'h1234, 4'b1000, 32'd0, 1'b1);
    step("passb",       32'h5,         32'hDEADBEEF, 4'b1011, 32'hDEADBEEF, 1'b0);

    // Async reset while a nonzero result is pending in the input stage.
    step("pre_reset",   32'd7,         32'd0,  4'b0000, 32'd7,  1'b0);
    @(negedge clk);
    a = 32'd9;
    b = 32'd9;
    Alu_ctrl = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("reset_hold", 32'h0, 1'b1);
    @(negedge clk);
    a = 32'd3;
    b = 32'd4;
    rst = 1'b0;
    #1;
    check("reset_release", 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check("post_reset_capture", 32'd7, 1'b0);

    // Back-to-back sweep of every code, one new operation per clock.
    for (int i = 0; i < 16; i++) begin
      x = $urandom();
      y = (i == 11) ? 32'hDEADBEEF : $urandom();
      e = ref_alu(x, y, 4'(i));
      if (i >= 12 && e !== 32'h0) begin
        n_cmp++;
        n_err++;
        $error("FAIL model_reserved: model gave %h, expected 0", e);
      end
      step($sformatf("sweep_op%0d", i), x, y, 4'(i), e, (e == 32'h0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got no summary, expected completion");
    $fatal(1, "timeout");
  end

endmodule
